// File: rtl/west_pp_stream_buffer.sv
// west_pp_stream_buffer
//   Ping-pong staging buffer for the west operand of the attention matmul
//   array. Row beats from the projection stream fill one bank (one tile)
//   while the other bank replays its tile NUM_PASSES times to the core.
//
// Ports
//   clk_i / rst_i            clock, synchronous active-high reset
//   in_valid_i / in_ready_o  producer handshake, in_data_i beat
//   out_valid_o / out_ready_i consumer handshake, out_data_o beat
//   out_last_o               beat at address DEPTH-1 of every pass
//   out_tile_done_o          last beat of last pass (frees the bank)
//   bank_full_o              bit i = bank i is FULL or DRAINING
//   err_overrun_o            sticky misuse flag, only with PP_OVERRUN_CHECK_EN
//
// Optional feature macro: PP_OVERRUN_CHECK_EN
//   Adds err_overrun_o plus state-transition assertions.
//
// Read path: a fetch pointer (fb/rd_addr/pass_cnt) reads the RAM into a
// 2-entry registered skid FIFO whose head drives the outputs. The fetch
// pointer may move on to the next bank before the previous tile's last beat
// has left the FIFO; the bank is only freed when out_tile_done handshakes,
// tracked separately by rd_bank_q.
module west_pp_stream_buffer #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 8,
  parameter int NUM_PASSES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  out_tile_done_o,
  output logic [1:0]            bank_full_o
`ifdef PP_OVERRUN_CHECK_EN
  ,
  output logic                  err_overrun_o
`endif
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int ENT_W  = DATA_WIDTH + 2;  // {tile_done, last, data}
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);

  // Encoding chosen so bit 1 means "holds a complete tile" and every legal
  // transition is +1 modulo 4.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0][1:0]       st_q, st_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic                  fb_q, fb_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [PASS_W-1:0]     pass_cnt_q, pass_cnt_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [ENT_W-1:0]      ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  run_q;
  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

  logic                  wr_fire, pop, fb_rdy, fetch, rd_last, rd_done, tile_free;
  logic [ENT_W-1:0]      new_ent;

  // run_q holds in_ready low through reset and for the first cycle after.
  assign in_ready_o = run_q && ((st_q[wr_bank_q] == ST_EMPTY) || (st_q[wr_bank_q] == ST_FILL));
  assign wr_fire    = in_valid_i && in_ready_o;

  assign out_valid_o     = (cnt_q != 2'd0);
  assign out_data_o      = ent0_q[DATA_WIDTH-1:0];
  assign out_last_o      = out_valid_o && ent0_q[DATA_WIDTH];
  assign out_tile_done_o = out_valid_o && ent0_q[DATA_WIDTH+1];
  assign bank_full_o     = {st_q[1][1], st_q[0][1]};

  assign pop       = out_valid_o && out_ready_i;
  assign tile_free = pop && ent0_q[DATA_WIDTH+1];
  assign fb_rdy    = st_q[fb_q][1];
  // Refill in the same cycle as a pop keeps a full-rate stream bubble-free.
  assign fetch     = fb_rdy && ((cnt_q != 2'd2) || pop);
  assign rd_last   = (rd_addr_q == ADDR_LAST);
  assign rd_done   = rd_last && (pass_cnt_q == PASS_LAST);
  assign new_ent   = {rd_done, rd_last, mem_q[fb_q][rd_addr_q]};

  always_comb begin
    st_d       = st_q;
    wr_bank_d  = wr_bank_q;
    wr_addr_d  = wr_addr_q;
    fb_d       = fb_q;
    rd_addr_d  = rd_addr_q;
    pass_cnt_d = pass_cnt_q;
    rd_bank_d  = rd_bank_q;
    ent0_d     = ent0_q;
    ent1_d     = ent1_q;
    cnt_d      = cnt_q;

    // Write side only ever touches an EMPTY/FILLING bank.
    if (wr_fire) begin
      if (wr_addr_q == ADDR_LAST) begin
        st_d[wr_bank_q] = ST_FULL;
        wr_bank_d       = ~wr_bank_q;
        wr_addr_d       = '0;
      end else begin
        st_d[wr_bank_q] = ST_FILL;
        wr_addr_d       = wr_addr_q + 1'b1;
      end
    end

    // Fetch side only ever touches a FULL/DRAINING bank.
    if (fetch) begin
      if (st_q[fb_q] == ST_FULL) st_d[fb_q] = ST_DRAIN;
      if (rd_last) begin
        rd_addr_d = '0;
        if (pass_cnt_q == PASS_LAST) begin
          pass_cnt_d = '0;
          fb_d       = ~fb_q;
        end else begin
          pass_cnt_d = pass_cnt_q + 1'b1;
        end
      end else begin
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end

    if (tile_free) begin
      st_d[rd_bank_q] = ST_EMPTY;
      rd_bank_d       = ~rd_bank_q;
    end

    // 2-entry skid FIFO, head in ent0.
    case ({fetch, pop})
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = new_ent;
        end else begin
          ent0_d = ent1_q;
          ent1_d = new_ent;
        end
      end
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = new_ent;
        else               ent1_d = new_ent;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q       <= '0;
      wr_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      fb_q       <= 1'b0;
      rd_addr_q  <= '0;
      pass_cnt_q <= '0;
      rd_bank_q  <= 1'b0;
      ent0_q     <= '0;
      ent1_q     <= '0;
      cnt_q      <= 2'd0;
      run_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      wr_bank_q  <= wr_bank_d;
      wr_addr_q  <= wr_addr_d;
      fb_q       <= fb_d;
      rd_addr_q  <= rd_addr_d;
      pass_cnt_q <= pass_cnt_d;
      rd_bank_q  <= rd_bank_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      cnt_q      <= cnt_d;
      run_q      <= 1'b1;
    end
  end

  // Tile storage; contents are meaningless once bank state is reset.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_bank_q][wr_addr_q] <= in_data_i;
  end

`ifdef PP_OVERRUN_CHECK_EN
  logic [ADDR_W:0] stall_cnt_q, idle_cnt_q;
  logic            err_q;
  logic            stall_c, idle_c;

  assign stall_c       = in_valid_i && !in_ready_o;
  assign idle_c        = out_ready_i && (bank_full_o == 2'b00) && (cnt_q == 2'd0);
  assign err_overrun_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      idle_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      // Stall counter saturates at DEPTH; one more stalled cycle trips it.
      if (stall_c) begin
        if (stall_cnt_q == (ADDR_W+1)'(DEPTH)) err_q <= 1'b1;
        else                                   stall_cnt_q <= stall_cnt_q + 1'b1;
      end else begin
        stall_cnt_q <= '0;
      end
      if (idle_c) begin
        if (idle_cnt_q == (ADDR_W+1)'(DEPTH - 1)) err_q <= 1'b1;
        else                                      idle_cnt_q <= idle_cnt_q + 1'b1;
      end else begin
        idle_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int b = 0; b < 2; b++) begin
        assert ((st_d[b] == st_q[b]) || (st_d[b] == st_q[b] + 2'd1));
      end
    end
  end
`endif

endmodule

// File: tb/tb_west_pp_stream_buffer.sv
module tb_west_pp_stream_buffer;
  localparam int DW = 16;
  localparam int D  = 4;
  localparam int NP = 2;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last, out_tile_done;
  logic [DW-1:0] in_data = '0, out_data;
  logic [1:0]    bank_full;
  logic          in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0, out_last2, out_tile_done2;
  logic [DW-1:0] in_data2 = '0, out_data2;
  logic [1:0]    bank_full2;
`ifdef PP_OVERRUN_CHECK_EN
  logic          err, err2;
`endif

  west_pp_stream_buffer #(.DATA_WIDTH(DW), .DEPTH(D), .NUM_PASSES(NP)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
    .out_tile_done_o(out_tile_done), .bank_full_o(bank_full)
`ifdef PP_OVERRUN_CHECK_EN
    , .err_overrun_o(err)
`endif
  );

  west_pp_stream_buffer #(.DATA_WIDTH(DW), .DEPTH(2), .NUM_PASSES(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid2), .in_ready_o(in_ready2), .in_data_i(in_data2),
    .out_valid_o(out_valid2), .out_ready_i(out_ready2), .out_data_o(out_data2), .out_last_o(out_last2),
    .out_tile_done_o(out_tile_done2), .bank_full_o(bank_full2)
`ifdef PP_OVERRUN_CHECK_EN
    , .err_overrun_o(err2)
`endif
  );

  int            checks = 0, errors = 0, popped = 0;
  bit            rand_mode = 1'b0;
  logic [DW+1:0] q[$], q2[$];
  logic [DW-1:0] wbuf[$];
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  // A completed tile expands to NP passes of D beats on the scoreboard.
  task automatic note_write(input logic [DW-1:0] d);
    wbuf.push_back(d);
    if (wbuf.size() == D) begin
      for (int p = 0; p < NP; p++)
        for (int a = 0; a < D; a++)
          q.push_back({(a == D-1) && (p == NP-1), (a == D-1), wbuf[a]});
      wbuf.delete();
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && k < 200) begin step(); k++; end
    chk("send_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    note_write(d);
  endtask

  task automatic wait_drain(input int bound);
    int k;
    k = 0;
    while (q.size() != 0 && k < bound) begin step(); k++; end
    chk("drain", q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; out_ready = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bank_full", bank_full, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {out_last, out_tile_done}, 0);
    q.delete(); q2.delete(); wbuf.delete();
    rst = 1'b0;
    chk("rdy_rst_low", in_ready, 0);
    step();
    chk("rdy_after_rst", in_ready, 1);
  endtask

  // Scoreboard pop and hold-stability check on the main instance.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        logic [DW+1:0] e;
        chk("sb_nonempty", (q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_data", out_data, e[DW-1:0]);
          chk("out_last", out_last, e[DW]);
          chk("tile_done", out_tile_done, e[DW+1]);
        end
        popped++;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k, idx, resume, n2;
    logic rdy;
    logic [DW+1:0] e;

    do_reset();

    // Single tile, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < D; i++) send_beat(DW'(16'hA0 + i));
    chk("t1_bank_full", bank_full, 2'b01);
    chk("t1_valid_p1", out_valid, 0);
    step();
    chk("t1_valid_p2", out_valid, 1);
    chk("t1_first", out_data, 16'hA0);
    wait_drain(50);
    chk("t1_empty", bank_full, 2'b00);
    step();
    chk("t1_idle", out_valid, 0);

    // Both banks fill with consumer stalled, then release.
    out_ready = 1'b0;
    for (int i = 0; i < 2*D; i++) send_beat(DW'(16'h10 + i));
    chk("t2_both_full", bank_full, 2'b11);
    in_valid = 1'b1; in_data = 16'h18; idx = 2*D;
    for (int c = 0; c < 3; c++) begin
      chk("t2_rdy_low", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    resume = -1;
    for (int c = 0; c < 3*D*NP; c++) begin
      chk("t2_nobubble", out_valid, 1);
      rdy = in_ready;
      if (rdy && resume < 0) resume = c;
      step();
      if (rdy && in_valid) begin
        note_write(in_data);
        idx++;
        if (idx == 3*D) in_valid = 1'b0;
        else            in_data = DW'(16'h10 + idx);
      end
    end
    chk("t2_resume", resume, D*NP);
    wait_drain(50);
    step();
    chk("t2_idle", out_valid, 0);
    chk("t2_empty", bank_full, 2'b00);

    // Random backpressure over three tiles.
    base = popped;
    rand_mode = 1'b1;
    for (int i = 0; i < 3*D; i++) send_beat(DW'(16'h30 + i));
    wait_drain(600);
    rand_mode = 1'b0;
    chk("t3_count", popped - base, 3*D*NP);

    // Reset in the middle of the second pass.
    out_ready = 1'b1;
    base = popped;
    for (int i = 0; i < D; i++) send_beat(DW'(16'hB0 + i));
    k = 0;
    while ((popped - base) < D + 2 && k < 100) begin step(); k++; end
    chk("t4_mid", popped - base, D + 2);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < D; i++) send_beat(DW'(16'hC0 + i));
    wait_drain(50);
    chk("t4_empty", bank_full, 2'b00);

    // DEPTH=2, NUM_PASSES=1 instance, back-to-back tiles.
    out_ready2 = 1'b1;
    n2 = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) begin
        in_valid2 = 1'b1;
        in_data2  = DW'(c + 1);
        chk("t5_rdy", in_ready2, 1);
      end else begin
        in_valid2 = 1'b0;
      end
      if (out_valid2) begin
        chk("t5_sb_nonempty", (q2.size() != 0), 1);
        if (q2.size() != 0) begin
          e = q2.pop_front();
          chk("t5_data", out_data2, e[DW-1:0]);
          chk("t5_last", out_last2, e[DW]);
          chk("t5_done", out_tile_done2, e[DW+1]);
        end
        n2++;
      end
      step();
      if (c < 4) q2.push_back({(c % 2) == 1, (c % 2) == 1, DW'(c + 1)});
    end
    chk("t5_count", n2, 4);
    chk("t5_left", q2.size(), 0);

`ifdef PP_OVERRUN_CHECK_EN
    do_reset();
    chk("t6_err_clear", err, 0);
    for (int i = 0; i < 2*D; i++) send_beat(DW'(16'h50 + i));
    in_valid = 1'b1; in_data = 16'h58;
    for (int c = 0; c <= D; c++) begin
      chk("t6_err_early", err, 0);
      step();
    end
    chk("t6_err_set", err, 1);
    in_valid = 1'b0;
    step(); step(); step();
    chk("t6_err_sticky", err, 1);
    do_reset();
    chk("t6_err_rst", err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/west_pp_stream_buffer.md
Name: west_pp_stream_buffer

Overview:
- Double-banked (ping-pong) staging buffer for the west operand of the attention matmul array.
- Accepts module-width row beats from the linear-projection output stream and stores one tile per bank.
- Replays each full tile NUM_PASSES times to the downstream systolic core while the other bank fills.
- Decouples the projection producer from the matmul consumer; both sides use valid/ready handshakes.

Parameters:
- DATA_WIDTH, 256, beat width in bits; equals W_MODULE_WIDTH in ping_pong_pkg.
- DEPTH, 8, beats per tile (per bank); equals W_TOTAL_DEPTH; must be ≥2.
- NUM_PASSES, 2, number of times each tile is replayed before its bank is freed; must be ≥1.
- ADDR_W, $clog2(DEPTH), address width (derived localparam).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer beat valid
- in_ready  out  1  buffer can accept a beat
- in_data  in  DATA_WIDTH  producer beat
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  DATA_WIDTH  output beat
- out_last  out  1  marks final beat of a pass (address DEPTH-1)
- out_tile_done  out  1  marks final beat of final pass; the bank is freed on its handshake
- bank_full  out  2  per-bank FULL/DRAINING status, bit i = bank i

Behaviour:
- Per-bank state: EMPTY → FILLING → FULL → DRAINING → EMPTY.
- Reset: both banks EMPTY; wr_bank=rd_bank=0; all pointers and counters 0; in_ready=0 during reset, 1 on the cycle after rst deasserts; out_valid, out_last, out_tile_done=0; out_data=0; bank_full=2'b00.
- Write side:
  - in_ready = 1 when bank[wr_bank] is EMPTY or FILLING.
  - On in_valid&&in_ready: store at wr_addr, then wr_addr+1.
  - On the handshake at wr_addr=DEPTH-1: bank becomes FULL next cycle, wr_bank toggles, wr_addr=0.
  - Holding in_valid with in_ready low has no effect; data is not consumed.
- Read side:
  - Reads from rd_bank in address order 0..DEPTH-1, repeated NUM_PASSES times (pass_cnt).
  - Output stage is registered with a 2-entry skid. out_data/out_valid stay stable while out_valid&&!out_ready.
  - With out_ready held high, one beat per cycle with no bubbles, including across passes and across banks when the next bank is already FULL.
- Latency: out_valid first rises 2 cycles after the final write handshake of a tile (bank FULL at +1, registered read data at +2).
- out_last=1 with the beat at address DEPTH-1 of every pass. out_tile_done=1 only on that beat in pass NUM_PASSES-1.
- Tile completion: on the out_tile_done handshake, bank[rd_bank] becomes EMPTY next cycle, rd_bank toggles, pass_cnt=0.
- Simultaneous events:
  - Free and refill of the same bank: if the write side is stalled on bank X and X is freed at cycle T, in_ready rises at T+1, never at T.
  - Writes to bank A and reads from bank B in the same cycle are independent and fully concurrent.
- Both banks FULL: in_ready=0 until one bank frees.
- Both banks EMPTY: out_valid=0.
- Reset mid-operation: all contents are discarded and every state returns to reset values on the next edge. No partial beat is emitted after rst.
- Arithmetic: data is passed through bit-exact, with no width change. Pointers wrap at DEPTH-1 and counters at NUM_PASSES-1 explicitly; the design does not rely on power-of-two overflow.

Optional Feature:
- Macro: PP_OVERRUN_CHECK_EN.
- Defined:
  - Adds output err_overrun (1 bit, sticky, cleared only by rst).
  - err_overrun sets the cycle after in_valid is held high with in_ready low for more than DEPTH consecutive cycles.
  - Also sets if out_ready is seen high while no bank is FULL/DRAINING and the skid buffer is empty for DEPTH consecutive cycles.
  - Includes simulation assertions that bank states never skip a transition.
- Undefined: the port, logic and assertions are absent; functional behaviour is otherwise identical.

Test Plan (DEPTH=4, NUM_PASSES=2 unless stated):
- Reset, then write beats 0xA0..0xA3 with out_ready=1 → bank_full=2'b01 one cycle after the 4th handshake; out_data sequence A0,A1,A2,A3,A0,A1,A2,A3 on consecutive cycles; out_last on beats 4 and 8; out_tile_done on beat 8 only; bank_full=00 afterwards.
- Stream 12 beats (0x10..0x1B) continuously with out_ready=0 → in_ready drops after beat 8 (both banks full), beats 0x18.. held. Then raise out_ready → tiles 0x10–0x13 ×2 then 0x14–0x17 ×2 are output with no bubbles; writes resume the cycle after the first tile frees.
- Toggle out_ready randomly (50%) over 3 tiles → out_data is stable whenever out_valid&&!out_ready; output order and count are exactly 2×DEPTH beats per tile.
- Assert rst after 2 beats of the second pass → next cycle out_valid=0, bank_full=00, in_ready=1 a cycle after rst drops; a fresh tile 0xC0..0xC3 replays correctly.
- NUM_PASSES=1, DEPTH=2: write 0x1,0x2,0x3,0x4 back-to-back with out_ready=1 → output 1,2,3,4 with out_tile_done on 2 and 4; in_ready never drops.
- With PP_OVERRUN_CHECK_EN defined: fill both banks, hold in_valid=1 and out_ready=0 for 5 cycles → err_overrun=1 and stays 1 until rst.
